// File: rtl/grid_stream_loader.sv
// rtl/grid_stream_loader.sv - decodes an '@'/'.' byte stream into a DEPTH x WIDTH occupancy grid
// Holds the finished grid until grid_ack; clr or reset abandon it.
module grid_stream_loader #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clr,
  input  logic                                  in_valid,
  input  logic [7:0]                            in_data,
  output logic                                  in_ready,
  output logic [WIDTH*DEPTH-1:0]                grid_out,
  output logic                                  grid_valid,
  input  logic                                  grid_ack,
  output logic [$clog2(WIDTH*DEPTH+1)-1:0]      rolls_total,
  output logic                                  err
);

  localparam int CELLS = WIDTH * DEPTH;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam int RW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int TW    = $clog2(CELLS + 1);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  localparam logic [CW-1:0] COL_FULL = CW'(WIDTH);
  localparam logic [RW-1:0] ROW_LAST = RW'(DEPTH - 1);
  localparam logic [IW-1:0] ROW_STEP = IW'(WIDTH);

  localparam logic [7:0] CH_ROLL  = 8'h40;
  localparam logic [7:0] CH_EMPTY = 8'h2E;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  logic [1:0]       state, state_n;
  logic [RW-1:0]    row, row_n;
  logic [CW-1:0]    col, col_n;
  logic [CELLS-1:0] grid_n;
  logic [TW-1:0]    total_n;
  logic [IW-1:0]    idx;

  assign in_ready   = (state == ST_LOAD);
  assign grid_valid = (state == ST_DONE);
  assign err        = (state == ST_ERR);

  // Row-major cell position; only used while col < WIDTH.
  assign idx = IW'(row) * ROW_STEP + IW'(col);

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    grid_n  = grid_out;
    total_n = rolls_total;
    if (clr || (state == ST_DONE && grid_ack)) begin
      state_n = ST_LOAD;
      row_n   = '0;
      col_n   = '0;
      grid_n  = '0;
      total_n = '0;
    end else if (state == ST_LOAD && in_valid) begin
      case (in_data)
        CH_ROLL, CH_EMPTY: begin
          if (col == COL_FULL) begin
            state_n = ST_ERR;
          end else begin
            grid_n[idx] = (in_data == CH_ROLL);
            col_n       = col + 1'b1;
            if (in_data == CH_ROLL) total_n = rolls_total + 1'b1;
          end
        end
        CH_CR: ;
        CH_LF: begin
          if (col == COL_FULL) begin
            col_n = '0;
            if (row == ROW_LAST) begin
              row_n   = '0;
              state_n = ST_DONE;
            end else begin
              row_n = row + 1'b1;
            end
          end else if (col != '0) begin
            state_n = ST_ERR;
          end
        end
        default: state_n = ST_ERR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_LOAD;
      row         <= '0;
      col         <= '0;
      grid_out    <= '0;
      rolls_total <= '0;
    end else begin
      state       <= state_n;
      row         <= row_n;
      col         <= col_n;
      grid_out    <= grid_n;
      rolls_total <= total_n;
    end
  end

endmodule

// File: tb/tb_grid_stream_loader.sv
// tb/tb_grid_stream_loader.sv - randomized self-checking bench for grid_stream_loader
// A 4x3 and a 16x16 instance share the input stream; sel picks whose handshake is followed.
module tb_grid_stream_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       grid_ack;
  logic       sel;

  logic        s_in_ready, s_grid_valid, s_err;
  logic [11:0] s_grid_out;
  logic [3:0]  s_rolls_total;

  logic         b_in_ready, b_grid_valid, b_err;
  logic [255:0] b_grid_out;
  logic [8:0]   b_rolls_total;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  grid_stream_loader #(.WIDTH(4), .DEPTH(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .grid_out(s_grid_out), .grid_valid(s_grid_valid),
    .grid_ack(grid_ack), .rolls_total(s_rolls_total), .err(s_err)
  );

  grid_stream_loader dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .grid_out(b_grid_out), .grid_valid(b_grid_valid),
    .grid_ack(grid_ack), .rolls_total(b_rolls_total), .err(b_err)
  );

  // Reference: in a legal stream the k-th cell character lands at bit k.
  function automatic logic [255:0] model_cells(input string s, output int total);
    logic [255:0] g;
    int k;
    g = '0;
    k = 0;
    total = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h40) begin
        g[k[7:0]] = 1'b1;
        total++;
        k++;
      end else if (s[i] == 8'h2E) begin
        k++;
      end
    end
    return g;
  endfunction

  task automatic send_byte(input byte b, input bit gaps);
    bit done;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    done = 1'b0;
    for (int t = 0; t < 50 && !done; t++) begin
      if (sel ? b_in_ready : s_in_ready) done = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: byte %h not accepted, required acceptance within 50 cycles", b);
    end
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gaps);
  endtask

  task automatic pulse(input bit do_clr, input bit do_ack);
    clr = do_clr;
    grid_ack = do_ack;
    @(negedge clk);
    clr = 1'b0;
    grid_ack = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (s_grid_out !== 12'h000) begin n_fail++; $display("FAIL reset_grid: got %h required 000", s_grid_out); end
    n_cmp++; if (s_grid_valid !== 1'b0 || s_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got valid=%b err=%b required 0/0", s_grid_valid, s_err); end
    n_cmp++; if (s_rolls_total !== 4'd0) begin n_fail++; $display("FAIL reset_total: got %0d required 0", s_rolls_total); end
    n_cmp++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", s_in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    send_str("@@.@\n....\n@@@@", 1'b0);
    n_cmp++; if (s_grid_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b required 0", s_grid_valid); end
    send_byte(8'h0A, 1'b0);
    n_cmp++; if (s_grid_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b required 1", s_grid_valid); end
    n_cmp++; if (s_grid_out !== 12'hF0B) begin n_fail++; $display("FAIL basic_grid: got %h required F0B", s_grid_out); end
    n_cmp++; if (s_rolls_total !== 4'd7) begin n_fail++; $display("FAIL basic_total: got %0d required 7", s_rolls_total); end
    n_cmp++; if (s_err !== 1'b0 || s_in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_flags: got err=%b ready=%b required 0/0", s_err, s_in_ready); end
  endtask

  task automatic test_hold_ack;
    in_valid = 1'b1;
    in_data  = 8'h40;
    repeat (5) begin
      @(negedge clk);
      n_cmp++; if (s_in_ready !== 1'b0 || s_grid_out !== 12'hF0B) begin n_fail++; $display("FAIL hold_grid: got ready=%b grid=%h required 0/F0B", s_in_ready, s_grid_out); end
    end
    in_valid = 1'b0;
    pulse(1'b0, 1'b1);
    n_cmp++; if (s_grid_valid !== 1'b0 || s_grid_out !== 12'h000) begin n_fail++; $display("FAIL ack_clear: got valid=%b grid=%h required 0/000", s_grid_valid, s_grid_out); end
    n_cmp++; if (s_rolls_total !== 4'd0 || s_in_ready !== 1'b1) begin n_fail++; $display("FAIL ack_state: got total=%0d ready=%b required 0/1", s_rolls_total, s_in_ready); end
  endtask

  task automatic test_crlf;
    string s;
    logic [255:0] g;
    int t;
    s = "\n@@@@\015\n\n....\015\n@...\n";
    g = model_cells(s, t);
    send_str(s, 1'b0);
    n_cmp++; if (s_grid_valid !== 1'b1 || s_grid_out !== g[11:0]) begin n_fail++; $display("FAIL crlf_grid: got valid=%b grid=%h required 1/%h", s_grid_valid, s_grid_out, g[11:0]); end
    n_cmp++; if (s_rolls_total !== 4'(t)) begin n_fail++; $display("FAIL crlf_total: got %0d required %0d", s_rolls_total, t); end
    pulse(1'b0, 1'b1);
  endtask

  task automatic test_short_row;
    send_str("@@\n", 1'b0);
    n_cmp++; if (s_err !== 1'b1 || s_in_ready !== 1'b0) begin n_fail++; $display("FAIL short_err: got err=%b ready=%b required 1/0", s_err, s_in_ready); end
    in_valid = 1'b1;
    in_data  = 8'h2E;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (s_in_ready !== 1'b0 || s_grid_out !== 12'h003 || s_rolls_total !== 4'd2) begin n_fail++; $display("FAIL short_frozen: got ready=%b grid=%h total=%0d required 0/003/2", s_in_ready, s_grid_out, s_rolls_total); end
    pulse(1'b1, 1'b1);
    n_cmp++; if (s_err !== 1'b0 || s_in_ready !== 1'b1 || s_grid_out !== 12'h000) begin n_fail++; $display("FAIL short_clr: got err=%b ready=%b grid=%h required 0/1/000", s_err, s_in_ready, s_grid_out); end
  endtask

  task automatic test_long_row;
    send_str("@@@@", 1'b0);
    n_cmp++; if (s_err !== 1'b0) begin n_fail++; $display("FAIL long_early: got err=%b required 0", s_err); end
    send_byte(8'h40, 1'b0);
    n_cmp++; if (s_err !== 1'b1 || s_rolls_total !== 4'd4) begin n_fail++; $display("FAIL long_err: got err=%b total=%0d required 1/4", s_err, s_rolls_total); end
    pulse(1'b1, 1'b0);
    send_str("@x", 1'b0);
    n_cmp++; if (s_err !== 1'b1 || s_rolls_total !== 4'd1 || s_grid_out !== 12'h001) begin n_fail++; $display("FAIL badchar: got err=%b total=%0d grid=%h required 1/1/001", s_err, s_rolls_total, s_grid_out); end
    pulse(1'b1, 1'b0);
  endtask

  task automatic test_clr_priority;
    send_str("@@", 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h40;
    pulse(1'b1, 1'b0);
    in_valid = 1'b0;
    n_cmp++; if (s_grid_out !== 12'h000 || s_rolls_total !== 4'd0) begin n_fail++; $display("FAIL clr_discard: got grid=%h total=%0d required 000/0", s_grid_out, s_rolls_total); end
    send_str("@...\n@...\n@...\n", 1'b0);
    n_cmp++; if (s_grid_valid !== 1'b1 || s_grid_out !== 12'h111 || s_rolls_total !== 4'd3) begin n_fail++; $display("FAIL clr_restart: got valid=%b grid=%h total=%0d required 1/111/3", s_grid_valid, s_grid_out, s_rolls_total); end
    pulse(1'b0, 1'b1);
  endtask

  task automatic test_async_reset;
    send_str("@@@@\n@.", 1'b0);
    n_cmp++; if (s_rolls_total !== 4'd5) begin n_fail++; $display("FAIL pre_reset_total: got %0d required 5", s_rolls_total); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (s_grid_out !== 12'h000 || s_rolls_total !== 4'd0 || s_grid_valid !== 1'b0 || s_err !== 1'b0) begin n_fail++; $display("FAIL async_reset: got grid=%h total=%0d valid=%b err=%b required 000/0/0/0", s_grid_out, s_rolls_total, s_grid_valid, s_err); end
    @(negedge clk);
    rst_n = 1'b1;
    send_str("@@.@\n....\n@@@@\n", 1'b0);
    n_cmp++; if (s_grid_out !== 12'hF0B || s_rolls_total !== 4'd7 || s_grid_valid !== 1'b1) begin n_fail++; $display("FAIL post_reset: got grid=%h total=%0d valid=%b required F0B/7/1", s_grid_out, s_rolls_total, s_grid_valid); end
    pulse(1'b0, 1'b1);
  endtask

  task automatic test_random_16;
    string s;
    logic [255:0] g;
    int t;
    sel = 1'b1;
    pulse(1'b1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      s = "";
      for (int r = 0; r < 16; r++) begin
        if ($urandom_range(0, 7) == 0) s = {s, "\n"};
        for (int c = 0; c < 16; c++) begin
          if ($urandom_range(0, 1) == 1) s = {s, "@"};
          else s = {s, "."};
        end
        if ($urandom_range(0, 1) == 1) s = {s, "\015\n"};
        else s = {s, "\n"};
      end
      g = model_cells(s, t);
      send_str(s, 1'b1);
      n_cmp++; if (b_grid_valid !== 1'b1 || b_err !== 1'b0) begin n_fail++; $display("FAIL rand_flags[%0d]: got valid=%b err=%b required 1/0", n, b_grid_valid, b_err); end
      n_cmp++; if (b_grid_out !== g) begin n_fail++; $display("FAIL rand_grid[%0d]: got %h required %h", n, b_grid_out, g); end
      n_cmp++; if (b_rolls_total !== 9'(t)) begin n_fail++; $display("FAIL rand_total[%0d]: got %0d required %0d", n, b_rolls_total, t); end
      pulse(1'b0, 1'b1);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    grid_ack = 1'b0;
    sel      = 1'b0;
    test_reset;
    test_basic;
    test_hold_ack;
    test_crlf;
    test_short_row;
    test_long_row;
    test_clr_priority;
    test_async_reset;
    test_random_16;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
